// File: rtl/endpoint_tx.sv
// Switch-port transmit endpoint: flit FIFO, per-VC credit tracking and a SEND/STALL gate.
// Define ENDPOINT_TX_STATS_EN to build the sent/stall statistics counters.
package endpoint_tx_pkg;
    localparam int VC_W = 4;

    typedef struct packed {
        logic [VC_W-1:0] vc;
    } metadata_t;

    typedef struct packed {
        metadata_t   metadata;
        logic [31:0] payload;
    } flit_t;
endpackage

module endpoint_tx
    import endpoint_tx_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int DEPTH       = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  flit_t                                         flit_in,
    input  logic                                          flit_valid,
    output logic                                          flit_ready,
    output flit_t                                         out,
    output logic                                          data_ready_out,
    input  logic                                          packet_sent,
    input  logic [NUM_VCS-1:0]                            credit_granted,
    output logic [NUM_VCS-1:0][$clog2(BUFFER_SIZE+1)-1:0] credit_count,
    output logic                                          credit_err,
    output logic [31:0]                                   sent_count,
    output logic [31:0]                                   stall_count
);
    localparam int CW   = $clog2(BUFFER_SIZE + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int VI_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_SIZE);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

    flit_t                     mem_q [DEPTH];
    flit_t                     mem_d [DEPTH];
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic [NUM_VCS-1:0][CW-1:0] credit_q, credit_d;
    logic                      err_q, err_d;
    state_t                    state_q, state_d;
    logic                      push, pop;
    logic [VI_W-1:0]           head_vc, next_vc;

    assign flit_ready     = (count_q != FULL);
    assign data_ready_out = (state_q == SEND);
    assign push           = flit_valid && flit_ready;
    assign pop            = data_ready_out && packet_sent;
    assign out            = mem_q[rd_ptr_q];
    assign head_vc        = VI_W'(out.metadata.vc);
    assign credit_count   = credit_q;
    assign credit_err     = err_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = flit_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head as it will be next cycle, including a flit pushed straight into the head slot.
        next_vc = VI_W'(mem_d[rd_ptr_d].metadata.vc);
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_granted[v] && !(pop && head_vc == VI_W'(v))) begin
                if (credit_q[v] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (!credit_granted[v] && pop && head_vc == VI_W'(v)) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    // State is registered from next-cycle FIFO/credit values so a new head is judged one cycle later.
    always_comb begin
        state_d = IDLE;
        if (count_d == '0) begin
            state_d = IDLE;
        end else if (credit_d[next_vc] != '0) begin
            state_d = SEND;
        end else begin
            state_d = STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= CRED_MAX;
            end
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

`ifdef ENDPOINT_TX_STATS_EN
    logic [31:0] sent_q, sent_d, stall_q, stall_d;

    always_comb begin
        sent_d  = sent_q;
        stall_d = stall_q;
        if (pop) begin
            sent_d = sent_q + 32'd1;
        end
        if (state_q == STALL) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign sent_count  = sent_q;
    assign stall_count = stall_q;
`else
    assign sent_count  = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_endpoint_tx.sv
// Directed self-checking bench for endpoint_tx; expected values are hand-computed per step.
module tb_endpoint_tx;
    import endpoint_tx_pkg::*;

`ifdef ENDPOINT_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    flit_t            flit_in;
    logic             flit_valid;
    logic             flit_ready;
    flit_t            out;
    logic             data_ready_out;
    logic             packet_sent;
    logic [1:0]       credit_granted;
    logic [1:0][3:0]  credit_count;
    logic             credit_err;
    logic [31:0]      sent_count;
    logic [31:0]      stall_count;

    int checks   = 0;
    int failures = 0;

    endpoint_tx #(.NUM_VCS(2), .BUFFER_SIZE(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_valid     (flit_valid),
        .flit_ready     (flit_ready),
        .out            (out),
        .data_ready_out (data_ready_out),
        .packet_sent    (packet_sent),
        .credit_granted (credit_granted),
        .credit_count   (credit_count),
        .credit_err     (credit_err),
        .sent_count     (sent_count),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(input int vc, input int payload);
        flit_t f;
        f.metadata.vc = 4'(vc);
        f.payload     = 32'(payload);
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        flit_valid     = 1'b0;
        packet_sent    = 1'b0;
        credit_granted = 2'b00;
        #2;
        step();
        rst = 1'b0;
    endtask

    // Push npush flits of one VC with packet_sent held high until nexp transfers are seen.
    task automatic push_and_send(input int vc, input int npush, input int nexp, input int base);
        int pushed = 0;
        int sent   = 0;
        packet_sent = 1'b1;
        for (int c = 0; c < 64 && !(pushed == npush && sent == nexp); c++) begin
            flit_valid = (pushed < npush);
            flit_in    = mk(vc, base + pushed);
            if (data_ready_out && packet_sent) begin
                check("xfer_order", out, mk(vc, base + sent));
                sent++;
            end
            if (flit_valid && flit_ready) pushed++;
            step();
        end
        flit_valid  = 1'b0;
        packet_sent = 1'b0;
        check("xfer_done", {pushed == npush, sent == nexp}, 2'b11);
    endtask

    initial begin
        rst            = 1'b0;
        flit_in        = '0;
        flit_valid     = 1'b0;
        packet_sent    = 1'b0;
        credit_granted = 2'b00;
        #3;
        rst = 1'b1;
        #2;
        check("rst_flit_ready", flit_ready, 1);
        check("rst_drdy", data_ready_out, 0);
        check("rst_out", out, 0);
        check("rst_credit0", credit_count[0], 8);
        check("rst_credit1", credit_count[1], 8);
        check("rst_err", credit_err, 0);
        check("rst_sent", sent_count, 0);
        check("rst_stall", stall_count, 0);
        step();
        rst = 1'b0;

        // Single flit, minimum latency.
        flit_valid  = 1'b1;
        flit_in     = mk(0, 'hA1);
        packet_sent = 1'b1;
        step();
        flit_valid = 1'b0;
        check("lat_drdy", data_ready_out, 1);
        check("lat_out", out, mk(0, 'hA1));
        step();
        packet_sent = 1'b0;
        check("lat_credit0", credit_count[0], 7);
        check("lat_drdy_after", data_ready_out, 0);

        // Asynchronous reset mid-transfer.
        flit_valid = 1'b1;
        flit_in    = mk(0, 'hB2);
        step();
        flit_valid = 1'b0;
        check("mid_drdy", data_ready_out, 1);
        rst = 1'b1;
        #2;
        check("async_credit0", credit_count[0], 8);
        check("async_drdy", data_ready_out, 0);
        check("async_ready", flit_ready, 1);
        check("async_out", out, 0);
        step();
        rst = 1'b0;

        // Four VC1 back-to-back transfers.
        push_and_send(1, 4, 4, 'h100);
        check("b2b_credit1", credit_count[1], 4);
        check("b2b_credit0", credit_count[0], 8);
        check("stats_sent4", sent_count, STATS ? 4 : 0);

        // Nine VC0 flits: eight go, the ninth stalls until a credit returns.
        push_and_send(0, 9, 8, 'h200);
        check("stall_drdy", data_ready_out, 0);
        check("stall_credit0", credit_count[0], 0);
        check("stall_cnt0", stall_count, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", data_ready_out, 0);
        end
        check("stall_head", out, mk(0, 'h208));
        check("stats_stall3", stall_count, STATS ? 3 : 0);
        check("stats_sent12", sent_count, STATS ? 12 : 0);
        credit_granted = 2'b01;
        step();
        credit_granted = 2'b00;
        check("resume_drdy", data_ready_out, 1);
        check("resume_out", out, mk(0, 'h208));
        packet_sent = 1'b1;
        step();
        packet_sent = 1'b0;
        check("resume_credit0", credit_count[0], 0);
        check("resume_idle", data_ready_out, 0);

        // Backpressure: out and data_ready_out hold while packet_sent is low.
        flit_valid = 1'b1;
        flit_in    = mk(1, 'h300);
        step();
        flit_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_drdy", data_ready_out, 1);
            check("hold_out", out, mk(1, 'h300));
            step();
        end
        packet_sent = 1'b1;
        step();
        packet_sent = 1'b0;
        check("hold_credit1", credit_count[1], 3);
        check("hold_done", data_ready_out, 0);

        // Grant and transfer on VC1 in the same cycle.
        flit_valid = 1'b1;
        flit_in    = mk(1, 'h301);
        step();
        flit_valid = 1'b0;
        check("same_drdy", data_ready_out, 1);
        packet_sent    = 1'b1;
        credit_granted = 2'b10;
        step();
        packet_sent    = 1'b0;
        credit_granted = 2'b00;
        check("same_credit1", credit_count[1], 3);
        check("same_err", credit_err, 0);

        // Simultaneous grants on both VCs.
        credit_granted = 2'b11;
        step();
        credit_granted = 2'b00;
        check("multi_credit0", credit_count[0], 1);
        check("multi_credit1", credit_count[1], 4);

        // FIFO full: fifth push is refused.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            flit_valid = 1'b1;
            flit_in    = mk(0, 'h400 + i);
            step();
        end
        flit_valid = 1'b0;
        check("full_ready", flit_ready, 0);
        check("full_drdy", data_ready_out, 1);
        check("full_head", out, mk(0, 'h400));
        push_and_send(0, 0, 4, 'h400);
        check("drain_drdy", data_ready_out, 0);
        check("drain_credit0", credit_count[0], 4);

        // Overflow at full credit is saturated and sticky.
        do_reset();
        credit_granted = 2'b01;
        step();
        credit_granted = 2'b00;
        check("ovf_credit0", credit_count[0], 8);
        check("ovf_err", credit_err, 1);
        repeat (3) step();
        check("ovf_sticky", credit_err, 1);
        do_reset();
        check("ovf_cleared", credit_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/endpoint_tx.md
ENDPOINT_TX -- requirements
Module: endpoint_tx

Interface
REQ-001 Parameter NUM_VCS, default 2, number of virtual channels on the switch port.
REQ-002 Parameter BUFFER_SIZE, default 8, per-VC flit credits held at reset; equals the downstream switch input-buffer depth.
REQ-003 Parameter DEPTH, default 4, local flit FIFO entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flit_in  input  flit_t  flit from local endpoint logic.
REQ-007 flit_valid  input  1  flit_in is valid.
REQ-008 flit_ready  output  1  FIFO not full; a flit is accepted when flit_valid and flit_ready are both high.
REQ-009 out  output  flit_t  flit to switch port 0.
REQ-010 data_ready_out  output  1  out is valid and credit is reserved.
REQ-011 packet_sent  input  1  switch consumed out this cycle.
REQ-012 credit_granted  input  NUM_VCS  per-VC one-cycle credit-return pulses.
REQ-013 credit_count  output  NUM_VCS x $clog2(BUFFER_SIZE+1)  current credits per VC.
REQ-014 credit_err  output  1  sticky credit-overflow flag.
REQ-015 sent_count  output  32  flits transferred (see Configuration).
REQ-016 stall_count  output  32  cycles spent in STALL (see Configuration).

Function
REQ-017 The FIFO shall be DEPTH entries; write on flit_valid & flit_ready, pop on data_ready_out & packet_sent; simultaneous push and pop when full is not allowed (flit_ready is low when full, regardless of pop).
REQ-018 The FSM shall have states IDLE (FIFO empty), SEND (head VC credit > 0), STALL (head VC credit == 0 with FIFO non-empty).
REQ-019 out shall equal the FIFO head at all times; data_ready_out shall be high only in SEND.
REQ-020 A flit written into an empty FIFO shall reach SEND no earlier than the next cycle (one-cycle minimum latency flit_valid -> data_ready_out).
REQ-021 Once data_ready_out is high, out and data_ready_out shall stay stable until the cycle packet_sent is sampled high.
REQ-022 On transfer, credit_count[head VC] shall decrement by one; the next head shall be evaluated in the following cycle (back-to-back transfers allowed when credit remains).
REQ-023 credit_granted[v] shall increment credit_count[v] by one; a grant and a transfer on the same VC in one cycle shall leave the count unchanged.
REQ-024 An increment beyond BUFFER_SIZE shall saturate at BUFFER_SIZE and set credit_err, which stays high until reset.
REQ-025 Grants for multiple VCs in one cycle shall all be applied.
REQ-026 STALL -> SEND in the cycle after credit for the head VC returns; SEND/STALL -> IDLE when the last flit pops.
REQ-027 The head VC shall be taken from out.metadata.vc; out-of-range VC values are illegal and unchecked.

Reset
REQ-028 On rst: FIFO empty, state IDLE, flit_ready=1, data_ready_out=0, out=0, credit_count[v]=BUFFER_SIZE for all v, credit_err=0, sent_count=0, stall_count=0.
REQ-029 Reset asserted mid-transfer shall discard all buffered flits and restore full credit immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro ENDPOINT_TX_STATS_EN: when defined, sent_count increments once per transfer and stall_count once per STALL cycle, both wrapping modulo 2^32.
REQ-031 Without ENDPOINT_TX_STATS_EN, sent_count and stall_count shall remain present and be driven constant 0, and no counter flops shall be built.

Verification
REQ-032 Reset, push 1 flit VC0, packet_sent held high -> data_ready_out high at cycle 1, transfer cycle 1, credit_count[0]=7.
REQ-033 Push 9 flits VC0, no grants -> 8 transfers, then STALL, data_ready_out=0, credit_count[0]=0; one credit_granted[0] pulse -> 9th flit sent the following cycle.
REQ-034 In SEND, hold packet_sent low for 5 cycles -> out unchanged and data_ready_out high throughout.
REQ-035 credit_count[1]=3 with same-cycle VC1 transfer and credit_granted[1] -> credit_count[1] stays 3.
REQ-036 At full credit, pulse credit_granted[0] -> credit_count[0] stays 8, credit_err=1 until rst.
REQ-037 With ENDPOINT_TX_STATS_EN, 4 transfers and 3 stall cycles -> sent_count=4, stall_count=3; without the macro both read 0.
